// File: rtl/iob_ext_mem_arbiter.sv
// rtl/iob_ext_mem_arbiter.sv - round-robin arbiter sharing one IOb-native slave among N masters
// A grant is held for one whole valid..ready transaction; priority then rotates past the winner.
module iob_ext_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]    m_rdata,
  output logic [N_MASTERS-1:0]           m_ready,
  output logic                           s_valid,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [DATA_W/8-1:0]            s_wstrb,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic                           s_ready,
  output logic [$clog2(N_MASTERS)-1:0]   grant_id,
  output logic                           busy
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Search ptr, ptr+1, ... with an explicit modulo so non-power-of-2 counts never go out of range.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand     = (int'(ptr) + k) % N_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!arb_found && m_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign ptr_next = (int'(grant_id) == N_MASTERS - 1) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            grant_id <= arb_idx;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            ptr   <= ptr_next;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The granted master's fields pass straight through; everything else reads as zero.
  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = '0;
    m_rdata = '0;
    if (state == ST_BUSY) begin
      s_valid                                      = 1'b1;
      s_addr                                       = m_addr[int'(grant_id)*ADDR_W +: ADDR_W];
      s_wdata                                      = m_wdata[int'(grant_id)*DATA_W +: DATA_W];
      s_wstrb                                      = m_wstrb[int'(grant_id)*STRB_W +: STRB_W];
      m_ready[grant_id]                            = s_ready;
      m_rdata[int'(grant_id)*DATA_W +: DATA_W]     = s_rdata;
    end
  end

  assign busy = (state == ST_BUSY);

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// tb/tb_iob_ext_mem_arbiter.sv - directed self-checking bench for iob_ext_mem_arbiter
module tb_iob_ext_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [63:0] m_rdata;
  logic [1:0]  m_ready;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [0:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  iob_ext_mem_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0;
    #3;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b1;
    m_valid = 2'b01;
    m_addr[31:0] = 32'h40;
    tick();
    #1;
    checks++; if (busy !== 1'b1 || s_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got=%b/%b exp=1/1", busy, s_valid); end
    tick();
    // stalled slave, async reset mid-cycle with no clock edge
    #1;
    rst = 1'b0;
    s_ready = 1'b1;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_async_s_valid got=%b exp=0", s_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_async_grant got=%0d exp=0", grant_id); end
    checks++; if (m_ready !== 2'b00 || s_addr !== 32'h0) begin errors++; $display("FAIL reset_async_outs got=%b/%h exp=00/0", m_ready, s_addr); end
    s_ready = 1'b0;
    rst = 1'b1;
    tick();
    #1;
    checks++; if (s_valid !== 1'b1 || grant_id !== 1'b0 || s_addr !== 32'h40) begin
      errors++; $display("FAIL reset_rearb got=%b/%0d/%h exp=1/0/00000040", s_valid, grant_id, s_addr);
    end
    s_ready = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL reset_rearb_ready got=%b exp=01", m_ready); end
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    #1;
  endtask

  task automatic test_read_m1();
    do_reset();
    m_valid = 2'b10;
    m_addr[63:32] = 32'h100;
    m_wstrb[7:4] = 4'h0;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL read_pre_s_valid got=%b exp=0", s_valid); end
    tick();
    #1;
    checks++; if (s_valid !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL read_grant got=%b/%0d exp=1/1", s_valid, grant_id); end
    checks++; if (s_addr !== 32'h100 || s_wstrb !== 4'h0) begin errors++; $display("FAIL read_fields got=%h/%h exp=00000100/0", s_addr, s_wstrb); end
    tick();
    tick();
    #1;
    checks++; if (m_ready !== 2'b00 || s_valid !== 1'b1) begin errors++; $display("FAIL read_wait got=%b/%b exp=00/1", m_ready, s_valid); end
    s_ready = 1'b1;
    s_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL read_m_ready got=%b exp=10", m_ready); end
    checks++; if (m_rdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m1_rdata got=%h exp=deadbeef", m_rdata[63:32]); end
    checks++; if (m_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL read_m0_rdata got=%h exp=0", m_rdata[31:0]); end
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
    m_valid = '0;
    #1;
    checks++; if (s_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_idle got=%b/%b exp=0/0", s_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_g;
    do_reset();
    m_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = 1'(i % 2);
      tick();
      #1;
      checks++; if (busy !== 1'b1 || grant_id !== exp_g) begin errors++; $display("FAIL rr_grant_%0d got=%b/%0d exp=1/%0d", i, busy, grant_id, exp_g); end
      tick();
      s_ready = 1'b1;
      #1;
      checks++; if (m_ready !== (2'b01 << exp_g)) begin errors++; $display("FAIL rr_ready_%0d got=%b exp=%b", i, m_ready, 2'b01 << exp_g); end
      tick();
      s_ready = 1'b0;
      #1;
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rr_gap_%0d got=%b exp=0", i, s_valid); end
    end
    m_valid = '0;
    tick();
  endtask

  task automatic test_late_request();
    do_reset();
    m_valid = 2'b01;
    tick();
    #1;
    checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL late_first got=%0d/%b exp=0/1", grant_id, busy); end
    m_valid = 2'b11;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    tick();
    #1;
    checks++; if (grant_id !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL late_m1_next got=%0d/%b exp=1/1", grant_id, busy); end
    s_ready = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL late_m1_ready got=%b exp=10", m_ready); end
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset();
    m_valid = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      s_ready = s_valid;
      #1;
      exp_v = (i % 2 == 0);
      checks++; if (s_valid !== exp_v || m_ready !== {1'b0, exp_v}) begin
        errors++; $display("FAIL b2b_cycle_%0d got=%b/%b exp=%b/0%b", i, s_valid, m_ready, exp_v, exp_v);
      end
    end
    m_valid = '0;
    tick();
    s_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_mux();
    do_reset();
    m_addr  = {32'hFFFFFFFF, 32'h00000080};
    m_wdata = {32'hFFFFFFFF, 32'h12345678};
    m_wstrb = {4'hF, 4'b0011};
    s_ready = 1'b1;
    #1;
    checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
      errors++; $display("FAIL wr_idle_fields got=%h/%h/%h exp=0/0/0", s_addr, s_wdata, s_wstrb);
    end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL wr_idle_sready got=%b exp=00", m_ready); end
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_stay got=%b exp=0", busy); end
    s_ready = 1'b0;
    m_valid = 2'b01;
    tick();
    #1;
    checks++; if (s_addr !== 32'h80 || s_wdata !== 32'h12345678 || s_wstrb !== 4'b0011) begin
      errors++; $display("FAIL wr_fields got=%h/%h/%h exp=00000080/12345678/3", s_addr, s_wdata, s_wstrb);
    end
    s_ready = 1'b1;
    s_rdata = 32'hAAAA5555;
    #1;
    checks++; if (m_ready !== 2'b01 || m_rdata !== {32'h0, 32'hAAAA5555}) begin
      errors++; $display("FAIL wr_done got=%b/%h exp=01/00000000aaaa5555", m_ready, m_rdata);
    end
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
    m_valid = '0;
    #1;
    checks++; if (s_valid !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
      errors++; $display("FAIL wr_after_idle got=%b/%h/%h/%h exp=0/0/0/0", s_valid, s_addr, s_wdata, s_wstrb);
    end
  endtask

  initial begin
    test_reset();
    test_read_m1();
    test_round_robin();
    test_late_request();
    test_back_to_back();
    test_write_mux();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
